// File: rtl/fios_result_collector.sv
// Tail of the FIOS PE chain: captures T word-serially, applies the final
// conditional subtraction (T >= p ? T-p : T) and streams the result LSW first.
module fios_result_collector #(
    parameter int unsigned N_WORDS = 16,
    parameter int unsigned WORD_W  = 17
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              res_valid_i,
    input  logic [WORD_W-1:0] res_word_i,
    input  logic [WORD_W-1:0] p_word_i,
    output logic              ready_o,
    output logic              busy_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [WORD_W-1:0] out_word_o,
    output logic              out_last_o,
    output logic              overrun_o
);

    localparam int unsigned IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int unsigned D_W   = WORD_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic               r_borrow;
    logic               w_borrow_nxt;
    logic               r_sel;
    logic               w_sel_nxt;
    logic [WORD_W-1:0]  r_tbuf [N_WORDS];
    logic [WORD_W-1:0]  r_dbuf [N_WORDS];

    logic               r_ready;
    logic               r_busy;
    logic               r_out_valid;
    logic [WORD_W-1:0]  r_out_word;
    logic               r_out_last;
    logic               r_overrun;
    logic               w_ready_nxt;
    logic               w_busy_nxt;
    logic               w_out_valid_nxt;
    logic [WORD_W-1:0]  w_out_word_nxt;
    logic               w_out_last_nxt;
    logic               w_overrun_nxt;

    logic [D_W-1:0]     w_d;
    logic               w_accept;
    logic               w_cap_last;
    logic               w_out_fire;
    logic               w_drain_last;

    // One limb of the multi-word subtraction, borrow rippling LSW to MSW.
    assign w_d          = {1'b0, res_word_i} - {1'b0, p_word_i} - D_W'(r_borrow);
    assign w_accept     = res_valid_i && (r_state != S_DRAIN);
    assign w_cap_last   = w_accept && (r_idx == LAST_IDX);
    assign w_out_fire   = r_out_valid && out_ready_i;
    assign w_drain_last = w_out_fire && (r_idx == LAST_IDX);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_borrow_nxt = r_borrow;
        w_sel_nxt    = r_sel;
        case (r_state)
            S_IDLE, S_CAPTURE: begin
                if (w_accept) begin
                    w_borrow_nxt = w_d[WORD_W];
                    if (w_cap_last) begin
                        w_state_nxt = S_DRAIN;
                        w_idx_nxt   = '0;
                        w_sel_nxt   = ~w_d[WORD_W];
                    end else begin
                        w_state_nxt = S_CAPTURE;
                        w_idx_nxt   = r_idx + IDX_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (w_drain_last) begin
                    w_state_nxt  = S_IDLE;
                    w_idx_nxt    = '0;
                    w_borrow_nxt = 1'b0;
                end else if (w_out_fire) begin
                    w_idx_nxt = r_idx + IDX_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Outputs are precomputed from next state so the word is ready the cycle after the last capture.
    always_comb begin
        w_ready_nxt     = (w_state_nxt != S_DRAIN);
        w_busy_nxt      = (w_state_nxt != S_IDLE);
        w_out_valid_nxt = (w_state_nxt == S_DRAIN);
        w_out_word_nxt  = '0;
        w_out_last_nxt  = 1'b0;
        w_overrun_nxt   = r_overrun | (res_valid_i && (r_state == S_DRAIN));
        if (w_out_valid_nxt) begin
            w_out_word_nxt = w_sel_nxt ? r_dbuf[w_idx_nxt] : r_tbuf[w_idx_nxt];
            w_out_last_nxt = (w_idx_nxt == LAST_IDX);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_idx       <= '0;
            r_borrow    <= 1'b0;
            r_sel       <= 1'b0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_word  <= '0;
            r_out_last  <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_idx       <= w_idx_nxt;
            r_borrow    <= w_borrow_nxt;
            r_sel       <= w_sel_nxt;
            r_ready     <= w_ready_nxt;
            r_busy      <= w_busy_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_word  <= w_out_word_nxt;
            r_out_last  <= w_out_last_nxt;
            r_overrun   <= w_overrun_nxt;
        end
    end

    // Result buffers carry no reset; they are always rewritten before being drained.
    always_ff @(posedge clock_i) begin
        if (!reset_i && w_accept) begin
            r_tbuf[r_idx] <= res_word_i;
            r_dbuf[r_idx] <= w_d[WORD_W-1:0];
        end
    end

    assign ready_o     = r_ready;
    assign busy_o      = r_busy;
    assign out_valid_o = r_out_valid;
    assign out_word_o  = r_out_word;
    assign out_last_o  = r_out_last;
    assign overrun_o   = r_overrun;

endmodule
